// File: rtl/vector_pkg.sv
// Shared definitions for the vector writeback path.
//   NUM_VREGS / VREG_W / VIDX_W : register file geometry
//   req_id_t                    : writeback requester id (ALU / load unit)
//   vidx_t / vreg_t             : register index / register data types
package vector_pkg;

    localparam int NUM_VREGS = 16;
    localparam int VREG_W    = 32;
    localparam int VIDX_W    = $clog2(NUM_VREGS);

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

    typedef logic [VIDX_W-1:0] vidx_t;
    typedef logic [VREG_W-1:0] vreg_t;

endpackage

// File: rtl/vector_scoreboard.sv
// Per-register busy scoreboard for the vector register file.
// A register goes busy when an instruction writing it issues and goes
// idle again when its writeback strobe reaches the register file.
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   issue_valid/vd/vs/vt            : instruction presented by issue stage
//   update_enable, update_index     : registered writeback strobe / index
//   hazard                          : issue must stall (RAW or WAW)
//   busy_mask                       : per-register pending-write bits
module vector_scoreboard
    import vector_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [VIDX_W-1:0]    issue_vd,
    input  logic [VIDX_W-1:0]    issue_vs,
    input  logic [VIDX_W-1:0]    issue_vt,
    input  logic                 update_enable,
    input  logic [VIDX_W-1:0]    update_index,
    output logic                 hazard,
    output logic [NUM_VREGS-1:0] busy_mask
);

    logic [NUM_VREGS-1:0] busy;
    logic [NUM_VREGS-1:0] busyNext;

    // Checking vd as well as the sources covers WAW; it also guarantees a
    // set never lands on an index being cleared in the same cycle.
    assign hazard = issue_valid &&
                    (busy[issue_vs] | busy[issue_vt] | busy[issue_vd]);

    // Clear first, then set, so a coincident set on the same index wins.
    always_comb begin
        busyNext = busy;
        if (update_enable) busyNext[update_index] = 1'b0;
        if (issue_valid && !hazard) busyNext[issue_vd] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) busy <= '0;
        else       busy <= busyNext;
    end

    assign busy_mask = busy;

endmodule

// File: rtl/vector_writeback_arbiter.sv
// Shares the vector register file write port between the vector ALU and
// the vector load unit. Round-robin valid/ready arbitration feeds one
// registered output stage that drives indexVd / update_register /
// update_enable. Optional busy scoreboard (macro VWB_SCOREBOARD_EN) flags
// RAW/WAW hazards to issue; without it hazard and busy_mask are 0 and the
// issue_* inputs are ignored.
// Ports:
//   clock, reset                         : clock, synchronous active-high reset
//   alu_valid/ready/index/data           : ALU writeback request
//   ld_valid/ready/index/data            : load-unit writeback request
//   update_enable/index/register         : register file write port
//   issue_valid/vd/vs/vt                 : issuing instruction registers
//   hazard, busy_mask                    : scoreboard outputs
module vector_writeback_arbiter
    import vector_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [VIDX_W-1:0]    alu_index,
    input  logic [VREG_W-1:0]    alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [VIDX_W-1:0]    ld_index,
    input  logic [VREG_W-1:0]    ld_data,
    output logic                 update_enable,
    output logic [VIDX_W-1:0]    update_index,
    output logic [VREG_W-1:0]    update_register,
    input  logic                 issue_valid,
    input  logic [VIDX_W-1:0]    issue_vd,
    input  logic [VIDX_W-1:0]    issue_vs,
    input  logic [VIDX_W-1:0]    issue_vt,
    output logic                 hazard,
    output logic [NUM_VREGS-1:0] busy_mask
);

    req_id_t lastGrant;
    logic    aluGrant;
    logic    ldGrant;

    // Grant is the ready: a lone requester always wins, a tie goes to the
    // side that did not win the previous transfer.
    always_comb begin
        aluGrant = 1'b0;
        ldGrant  = 1'b0;
        if (!reset) begin
            if (alu_valid && ld_valid) begin
                aluGrant = (lastGrant == REQ_LD);
                ldGrant  = (lastGrant == REQ_ALU);
            end else begin
                aluGrant = alu_valid;
                ldGrant  = ld_valid;
            end
        end
    end

    assign alu_ready = aluGrant;
    assign ld_ready  = ldGrant;

    // Index/data hold their last value when idle; only the strobe drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            update_enable   <= 1'b0;
            update_index    <= '0;
            update_register <= '0;
            lastGrant       <= REQ_LD;
        end else begin
            update_enable <= aluGrant | ldGrant;
            if (aluGrant) begin
                update_index    <= alu_index;
                update_register <= alu_data;
                lastGrant       <= REQ_ALU;
            end else if (ldGrant) begin
                update_index    <= ld_index;
                update_register <= ld_data;
                lastGrant       <= REQ_LD;
            end
        end
    end

`ifdef VWB_SCOREBOARD_EN
    vector_scoreboard u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_vd      (issue_vd),
        .issue_vs      (issue_vs),
        .issue_vt      (issue_vt),
        .update_enable (update_enable),
        .update_index  (update_index),
        .hazard        (hazard),
        .busy_mask     (busy_mask)
    );
`else
    logic unusedIssue;
    assign unusedIssue = ^{issue_valid, issue_vd, issue_vs, issue_vt};
    assign hazard      = 1'b0;
    assign busy_mask   = '0;
`endif

endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// Bench for vector_writeback_arbiter: directed vector table, hand-written
// scoreboard sequences, then random traffic against a behavioural model.
module tb_vector_writeback_arbiter;

`ifdef VWB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid, alu_ready, ld_ready;
    logic [3:0]  alu_index, ld_index;
    logic [31:0] alu_data, ld_data;
    logic        update_enable;
    logic [3:0]  update_index;
    logic [31:0] update_register;
    logic        issue_valid;
    logic [3:0]  issue_vd, issue_vs, issue_vt;
    logic        hazard;
    logic [15:0] busy_mask;

    always #5 clock = ~clock;

    vector_writeback_arbiter dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_index(ld_index), .ld_data(ld_data),
        .update_enable(update_enable), .update_index(update_index), .update_register(update_register),
        .issue_valid(issue_valid), .issue_vd(issue_vd), .issue_vs(issue_vs), .issue_vt(issue_vt),
        .hazard(hazard), .busy_mask(busy_mask)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mEn;
    bit [3:0]    mIdx;
    bit [31:0]   mData;
    bit          mAluNextTie;       // who wins the next tie
    bit          mBusy [16];
    bit          eAr, eLr, eHaz;

    function automatic bit [15:0] modelMask();
        bit [15:0] m = '0;
        for (int i = 0; i < 16; i++) if (mBusy[i]) m |= 16'(1) << i;
        return m;
    endfunction

    task automatic modelComb();
        eAr = 0; eLr = 0;
        if (!reset) begin
            if (alu_valid && ld_valid) begin
                eAr = mAluNextTie;
                eLr = !mAluNextTie;
            end else begin
                eAr = alu_valid;
                eLr = ld_valid;
            end
        end
        eHaz = SB && issue_valid &&
               (mBusy[issue_vs] || mBusy[issue_vt] || mBusy[issue_vd]);
    endtask

    task automatic modelEdge();
        modelComb();
        if (reset) begin
            mEn = 0; mIdx = 0; mData = 0; mAluNextTie = 1;
            for (int i = 0; i < 16; i++) mBusy[i] = 0;
        end else begin
            if (SB) begin
                if (mEn) mBusy[mIdx] = 0;
                if (issue_valid && !eHaz) mBusy[issue_vd] = 1;
            end
            mEn = eAr || eLr;
            if (eAr) begin mIdx = alu_index; mData = alu_data; mAluNextTie = 0; end
            else if (eLr) begin mIdx = ld_index; mData = ld_data; mAluNextTie = 1; end
        end
    endtask

    bit sawAr, sawLr;

    task automatic stepCheck();
        @(negedge clock);
        modelComb();
        sawAr = alu_ready; sawLr = ld_ready;
        chk("m_alu_ready", {31'b0, alu_ready}, {31'b0, eAr});
        chk("m_ld_ready", {31'b0, ld_ready}, {31'b0, eLr});
        chk("m_update_enable", {31'b0, update_enable}, {31'b0, mEn});
        chk("m_update_index", {28'b0, update_index}, {28'b0, mIdx});
        chk("m_update_register", update_register, mData);
        chk("m_hazard", {31'b0, hazard}, {31'b0, eHaz});
        chk("m_busy_mask", {16'b0, busy_mask}, {16'b0, modelMask()});
    endtask

    task automatic stepAdvance();
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit av; logic [3:0] ai; logic [31:0] ad;
        bit lv; logic [3:0] li; logic [31:0] ldd;
        bit ear; bit elr; bit een; logic [3:0] eidx; logic [31:0] edat;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t row(bit rst, bit av, logic [3:0] ai, logic [31:0] ad,
                                 bit lv, logic [3:0] li, logic [31:0] ldd,
                                 bit ear, bit elr, bit een, logic [3:0] eidx, logic [31:0] edat);
        vec_t v;
        v.rst = rst; v.av = av; v.ai = ai; v.ad = ad; v.lv = lv; v.li = li; v.ldd = ldd;
        v.ear = ear; v.elr = elr; v.een = een; v.eidx = eidx; v.edat = edat;
        return v;
    endfunction

    localparam logic [31:0] DA = 32'hAAAA0008;
    localparam logic [31:0] DL = 32'h55550009;

    initial begin
        // reset held: readies low even with valids; reset state visible
        tbl[0]  = row(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 4'd0, 32'h0,       1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        // ALU-only write, latency one cycle, strobe one cycle, data held
        tbl[1]  = row(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,       1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
        tbl[2]  = row(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF);
        tbl[3]  = row(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF);
        // reset, then tie: ALU first, LD next
        tbl[4]  = row(1'b1, 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF);
        tbl[5]  = row(1'b0, 1'b1, 4'd1, 32'h11111111, 1'b1, 4'd2, 32'h22222222, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
        tbl[6]  = row(1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'd2, 32'h22222222, 1'b0, 1'b1, 1'b1, 4'd1, 32'h11111111);
        tbl[7]  = row(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 4'd2, 32'h22222222);
        tbl[8]  = row(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b0, 4'd2, 32'h22222222);
        // sustained tie: alternate ALU, LD, ...
        tbl[9]  = row(1'b0, 1'b1, 4'd8, DA, 1'b1, 4'd9, DL, 1'b1, 1'b0, 1'b0, 4'd2, 32'h22222222);
        tbl[10] = row(1'b0, 1'b1, 4'd8, DA, 1'b1, 4'd9, DL, 1'b0, 1'b1, 1'b1, 4'd8, DA);
        tbl[11] = row(1'b0, 1'b1, 4'd8, DA, 1'b1, 4'd9, DL, 1'b1, 1'b0, 1'b1, 4'd9, DL);
        tbl[12] = row(1'b0, 1'b1, 4'd8, DA, 1'b1, 4'd9, DL, 1'b0, 1'b1, 1'b1, 4'd8, DA);
        tbl[13] = row(1'b0, 1'b1, 4'd8, DA, 1'b1, 4'd9, DL, 1'b1, 1'b0, 1'b1, 4'd9, DL);
        tbl[14] = row(1'b0, 1'b1, 4'd8, DA, 1'b1, 4'd9, DL, 1'b0, 1'b1, 1'b1, 4'd8, DA);
        // accepted transfer, then reset mid-flight drops the staged write
        tbl[15] = row(1'b0, 1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd9, DL);
        tbl[16] = row(1'b1, 1'b1, 4'd4, 32'h44444444, 1'b1, 4'd9, DL,   1'b0, 1'b0, 1'b1, 4'd4, 32'h44444444);
        tbl[17] = row(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        tbl[18] = row(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    end

    initial begin
        reset = 1; alu_valid = 0; ld_valid = 0; alu_index = 0; ld_index = 0;
        alu_data = 0; ld_data = 0; issue_valid = 0; issue_vd = 0; issue_vs = 0; issue_vt = 0;
        stepAdvance();
        stepAdvance();

        for (int r = 0; r < 19; r++) begin
            reset = tbl[r].rst;
            alu_valid = tbl[r].av; alu_index = tbl[r].ai; alu_data = tbl[r].ad;
            ld_valid = tbl[r].lv; ld_index = tbl[r].li; ld_data = tbl[r].ldd;
            @(negedge clock);
            chk($sformatf("t%0d_alu_ready", r), {31'b0, alu_ready}, {31'b0, tbl[r].ear});
            chk($sformatf("t%0d_ld_ready", r), {31'b0, ld_ready}, {31'b0, tbl[r].elr});
            chk($sformatf("t%0d_update_enable", r), {31'b0, update_enable}, {31'b0, tbl[r].een});
            chk($sformatf("t%0d_update_index", r), {28'b0, update_index}, {28'b0, tbl[r].eidx});
            chk($sformatf("t%0d_update_register", r), update_register, tbl[r].edat);
            if (r == 17) chk("t17_busy_mask", {16'b0, busy_mask}, 32'h0);
            stepAdvance();
        end
        alu_valid = 0; ld_valid = 0;

        // ---- scoreboard sequence (expectations collapse to 0 when disabled) ----
        issue_valid = 1; issue_vd = 5; issue_vs = 0; issue_vt = 1;
        stepCheck(); chk("hz_first_issue", {31'b0, hazard}, 32'h0); stepAdvance();
        issue_vd = 6; issue_vs = 5; issue_vt = 0;
        stepCheck();
        chk("hz_busy5", {16'b0, busy_mask}, SB ? 32'h0020 : 32'h0);
        chk("hz_raw", {31'b0, hazard}, {31'b0, SB});
        stepAdvance();
        issue_valid = 0; ld_valid = 1; ld_index = 5; ld_data = 32'h0000_0555;
        stepCheck(); chk("hz_ld_ready", {31'b0, ld_ready}, 32'h1); stepAdvance();
        ld_valid = 0; issue_valid = 1; issue_vd = 6; issue_vs = 5; issue_vt = 0;
        stepCheck(); chk("hz_still_n1", {31'b0, hazard}, {31'b0, SB}); stepAdvance();
        stepCheck(); chk("hz_drop_n2", {31'b0, hazard}, 32'h0); stepAdvance();
        issue_vd = 7; issue_vs = 0; issue_vt = 1;
        stepCheck(); stepAdvance();
        issue_vd = 7; issue_vs = 2; issue_vt = 3;
        stepCheck(); chk("waw_hazard", {31'b0, hazard}, {31'b0, SB}); stepAdvance();
        issue_valid = 0;
        stepCheck(); chk("waw_busy", {16'b0, busy_mask}, SB ? 32'h00C0 : 32'h0); stepAdvance();

        // ---- random traffic; requesters hold requests until accepted ----
        for (int c = 0; c < 600; c++) begin
            if (!alu_valid || sawAr) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_index = 4'($urandom_range(0, 15));
                alu_data = $urandom;
            end
            if (!ld_valid || sawLr) begin
                ld_valid = ($urandom_range(0, 2) != 0);
                ld_index = 4'($urandom_range(0, 15));
                ld_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_vd = 4'($urandom_range(0, 15));
            issue_vs = 4'($urandom_range(0, 15));
            issue_vt = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 59) == 0);
            stepCheck();
            stepAdvance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
